// File: rtl/siso_frame_serializer_pkg.sv
// Items shared between the frame serializer and the downstream SISO stage.
package siso_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } ser_state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  localparam int SISO_DEPTH = 4;

endpackage

// File: rtl/siso_frame_serializer_bit_counter.sv
// Loadable down-counter with a zero flag; times both the DATA and FLUSH intervals.
module frame_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;

  // Saturates at zero so a stray decrement can never wrap into a long interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/siso_frame_serializer.sv
// Word-to-bitstream framer feeding the 4-bit SISO stage, with direction flush.
// Optional even-parity bit is compiled in when SISO_SERIALIZER_PARITY_EN is defined.
module siso_frame_serializer
  import siso_frame_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int FLUSH_CYCLES = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_msb_first,
  input  logic              in_dir,
  output logic              serial_in,
  output logic              shift_dir,
  output logic              busy,
  output logic              frame_done
);

  // Never flush for fewer cycles than it takes to drain the SISO stage.
  localparam int FLUSH_N = (FLUSH_CYCLES < SISO_DEPTH + 1) ? SISO_DEPTH + 1 : FLUSH_CYCLES;
  localparam int CNT_MAX = (DATA_W > FLUSH_N) ? DATA_W : FLUSH_N;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DATA_LOAD  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_N - 1);

  ser_state_t        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              msb_q, msb_d;
  logic              dir_q, dir_d;
  logic              serial_q, serial_d;
  logic              shift_dir_q, shift_dir_d;
  logic              frame_done_q;
  logic              accept;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_dec;
  logic              cnt_zero;

`ifdef SISO_SERIALIZER_PARITY_EN
  logic parity_q, parity_d;
`endif

  frame_bit_counter #(
    .W (CNT_W)
  ) u_bit_counter (
    .clk      (clk),
    .rst_n    (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign in_ready = (state_q == IDLE) || (state_q == STOP);
  assign accept   = in_valid && in_ready;

  // serial_d is the bit belonging to the current state; it reaches the pin one edge later.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    msb_d        = msb_q;
    dir_d        = dir_q;
    serial_d     = IDLE_LEVEL;
    shift_dir_d  = shift_dir_q;
    cnt_load     = 1'b0;
    cnt_load_val = DATA_LOAD;
    cnt_dec      = 1'b0;
`ifdef SISO_SERIALIZER_PARITY_EN
    parity_d     = parity_q;
`endif

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      FLUSH: begin
        if (cnt_zero) begin
          state_d = START;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      START: begin
        serial_d     = START_BIT;
        shift_dir_d  = dir_q;
        state_d      = DATA;
        cnt_load     = 1'b1;
        cnt_load_val = DATA_LOAD;
      end
      DATA: begin
        serial_d = msb_q ? data_q[DATA_W-1] : data_q[0];
        data_d   = msb_q ? (data_q << 1) : (data_q >> 1);
        if (cnt_zero) begin
`ifdef SISO_SERIALIZER_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          cnt_dec = 1'b1;
        end
      end
`ifdef SISO_SERIALIZER_PARITY_EN
      PARITY: begin
        serial_d = parity_q;
        state_d  = STOP;
      end
`endif
      STOP: begin
        serial_d = STOP_BIT;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Accept is only possible in IDLE or STOP; it overrides the return to IDLE.
    if (accept) begin
      data_d = in_data;
      msb_d  = in_msb_first;
      dir_d  = in_dir;
`ifdef SISO_SERIALIZER_PARITY_EN
      parity_d = ^in_data;
`endif
      if (in_dir != shift_dir_q) begin
        state_d      = FLUSH;
        cnt_load     = 1'b1;
        cnt_load_val = FLUSH_LOAD;
      end else begin
        state_d = START;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      data_q       <= '0;
      msb_q        <= 1'b0;
      dir_q        <= 1'b0;
      serial_q     <= IDLE_LEVEL;
      shift_dir_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      msb_q        <= msb_d;
      dir_q        <= dir_d;
      serial_q     <= serial_d;
      shift_dir_q  <= shift_dir_d;
      frame_done_q <= (state_q == STOP);
    end
  end

`ifdef SISO_SERIALIZER_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign serial_in  = serial_q;
  assign shift_dir  = shift_dir_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_siso_frame_serializer.sv
// Directed bench for siso_frame_serializer: frame content, timing, flush and reset.
module tb_siso_frame_serializer;

  localparam int DATA_W       = 8;
  localparam int FLUSH_CYCLES = 5;

`ifdef SISO_SERIALIZER_PARITY_EN
  localparam int L = DATA_W + 3;
  localparam logic [L-1:0] SEQ_A5  = 11'b11010010100;
  localparam logic [L-1:0] SEQ_01  = 11'b11000000010;
  localparam logic [L-1:0] SEQ_80  = 11'b10000000110;
  localparam logic [L-1:0] SEQ_0F  = 11'b11111000000;
  localparam logic [L-1:0] SEQ_C1M = 11'b11100000110;
  localparam logic [L-1:0] SEQ_96  = 11'b10110100100;
`else
  localparam int L = DATA_W + 2;
  localparam logic [L-1:0] SEQ_A5  = 10'b1101001010;
  localparam logic [L-1:0] SEQ_01  = 10'b1100000000;
  localparam logic [L-1:0] SEQ_80  = 10'b1000000010;
  localparam logic [L-1:0] SEQ_0F  = 10'b1111100000;
  localparam logic [L-1:0] SEQ_C1M = 10'b1110000010;
  localparam logic [L-1:0] SEQ_96  = 10'b1011010010;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_msb_first;
  logic              in_dir;
  logic              serial_in;
  logic              shift_dir;
  logic              busy;
  logic              frame_done;

  int checks = 0;
  int errors = 0;
  logic [2*L-1:0] exp;

  siso_frame_serializer #(
    .DATA_W       (DATA_W),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_msb_first (in_msb_first),
    .in_dir       (in_dir),
    .serial_in    (serial_in),
    .shift_dir    (shift_dir),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_msb_first = 1'b0; in_dir = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({serial_in, shift_dir, in_ready, busy, frame_done} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_hold outputs=%b expected 00100", {serial_in, shift_dir, in_ready, busy, frame_done});
    end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({serial_in, shift_dir, in_ready, busy} !== 4'b0010) begin
        errors++;
        $display("FAIL idle_cycle%0d serial/dir/ready/busy=%b expected 0010", i, {serial_in, shift_dir, in_ready, busy});
      end
    end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_lsb_first();
    exp = (2*L)'(SEQ_A5);
    @(negedge clk);
    in_data = 8'hA5; in_msb_first = 1'b0; in_dir = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; in_data = 8'h5A; in_msb_first = 1'b1;
    @(negedge clk);
    checks++;
    if ({serial_in, busy, in_ready} !== 3'b010) begin
      errors++;
      $display("FAIL lsb_latency serial/busy/ready=%b expected 010", {serial_in, busy, in_ready});
    end
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      checks++;
      if ({serial_in, frame_done} !== {exp[L-1-i], (i == L-1)}) begin
        errors++;
        $display("FAIL lsb_bit%0d serial/done=%b expected %b", i, {serial_in, frame_done}, {exp[L-1-i], (i == L-1)});
      end
    end
    @(negedge clk);
    checks++;
    if ({serial_in, busy, frame_done, in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL lsb_after serial/busy/done/ready=%b expected 0001", {serial_in, busy, frame_done, in_ready});
    end
    $display("test_lsb_first done: 0xA5 frame of %0d bits, errors=%0d", L, errors);
  endtask

  task automatic test_back_to_back();
    exp = {SEQ_01, SEQ_80};
    @(negedge clk);
    in_data = 8'h01; in_msb_first = 1'b0; in_dir = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_data = 8'h80;
    @(negedge clk);
    for (int i = 0; i < 2*L; i++) begin
      @(negedge clk);
      checks++;
      if ({serial_in, frame_done} !== {exp[2*L-1-i], (i == L-1) || (i == 2*L-1)}) begin
        errors++;
        $display("FAIL b2b_bit%0d serial/done=%b expected %b", i, {serial_in, frame_done},
                 {exp[2*L-1-i], (i == L-1) || (i == 2*L-1)});
      end
      if (i == L-2) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_stop_ready in_ready=%b expected 1", in_ready);
        end
      end
      if (i == L-1) in_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({serial_in, busy} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_after serial/busy=%b expected 00", {serial_in, busy});
    end
    $display("test_back_to_back done: 0x01,0x80 errors=%0d", errors);
  endtask

  task automatic test_flush();
    exp = (2*L)'(SEQ_0F);
    @(negedge clk);
    in_data = 8'h0F; in_msb_first = 1'b0; in_dir = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; in_dir = 1'b0;
    @(negedge clk);
    for (int j = 0; j < FLUSH_CYCLES; j++) begin
      @(negedge clk);
      checks++;
      if ({serial_in, shift_dir, in_ready, busy} !== 4'b0001) begin
        errors++;
        $display("FAIL flush_cycle%0d serial/dir/ready/busy=%b expected 0001", j, {serial_in, shift_dir, in_ready, busy});
      end
    end
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      checks++;
      if ({serial_in, shift_dir, frame_done} !== {exp[L-1-i], 1'b1, (i == L-1)}) begin
        errors++;
        $display("FAIL flush_bit%0d serial/dir/done=%b expected %b", i, {serial_in, shift_dir, frame_done},
                 {exp[L-1-i], 1'b1, (i == L-1)});
      end
    end
    $display("test_flush done: dir 0->1 with 0x0F errors=%0d", errors);
  endtask

  task automatic test_msb_first();
    exp = (2*L)'(SEQ_C1M);
    @(negedge clk);
    in_data = 8'hC1; in_msb_first = 1'b1; in_dir = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      checks++;
      if ({serial_in, shift_dir, frame_done} !== {exp[L-1-i], 1'b1, (i == L-1)}) begin
        errors++;
        $display("FAIL msb_bit%0d serial/dir/done=%b expected %b", i, {serial_in, shift_dir, frame_done},
                 {exp[L-1-i], 1'b1, (i == L-1)});
      end
      // Offer a word while busy and withdraw it before STOP: it must not be taken.
      if (i == 2) begin in_data = 8'hFF; in_valid = 1'b1; end
      if (i == 4) in_valid = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({serial_in, busy, in_ready} !== 3'b001) begin
        errors++;
        $display("FAIL msb_idle%0d serial/busy/ready=%b expected 001", i, {serial_in, busy, in_ready});
      end
    end
    $display("test_msb_first done: 0xC1 errors=%0d", errors);
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    in_data = 8'hFF; in_msb_first = 1'b0; in_dir = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({serial_in, shift_dir} !== 2'b11) begin
        errors++;
        $display("FAIL rst_pre_bit%0d serial/dir=%b expected 11", i, {serial_in, shift_dir});
      end
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({serial_in, shift_dir, in_ready, busy, frame_done} !== 5'b00100) begin
      errors++;
      $display("FAIL rst_async outputs=%b expected 00100", {serial_in, shift_dir, in_ready, busy, frame_done});
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp = (2*L)'(SEQ_96);
    @(negedge clk);
    in_data = 8'h96; in_msb_first = 1'b0; in_dir = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      checks++;
      if ({serial_in, shift_dir, frame_done} !== {exp[L-1-i], 1'b0, (i == L-1)}) begin
        errors++;
        $display("FAIL rst_post_bit%0d serial/dir/done=%b expected %b", i, {serial_in, shift_dir, frame_done},
                 {exp[L-1-i], 1'b0, (i == L-1)});
      end
    end
    $display("test_reset_midframe done: 0x96 after reset errors=%0d", errors);
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_back_to_back();
    test_flush();
    test_msb_first();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
